mko_bus_ctrl: RTL and testbench

MKO_BUS_CTRL -- requirements
Module: mko_bus_ctrl

---
 rtl/mko_pkg.sv | 16 +
 rtl/mko_chan_cfg.sv | 63 ++++++
 rtl/mko_bus_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mko_bus_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mko_pkg.sv
// Shared definitions for the MKO bus controller: device FSM states and
// register-map constants used by the top level and the channel config blocks.
package mko_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STRB,
    ST_DONE
  } mko_state_t;

  localparam logic [3:0] STATUS_OFS   = 4'hF;
  localparam int         RES_N_BIT    = 15;
  localparam int         AUTO_RES_BIT = 14;

endpackage

// File: rtl/mko_chan_cfg.sv
// One MKO channel's configuration: static RES_N level, RT address bits,
// auto-reset pulse counter and the odd-parity bit for the RT address.
module mko_chan_cfg
  import mko_pkg::*;
#(
  parameter int RES_CYC = 16
) (
  input  logic       CLK_32,
  input  logic       RESET,
  input  logic       i_wr,
  input  logic       i_res_lvl,
  input  logic       i_auto_res,
  input  logic [4:0] i_rdat,
  output logic       o_res_n,
  output logic       o_res_lvl,
  output logic [4:0] o_rdat,
  output logic       o_rdatp,
  output logic       o_pulse
);

  localparam int CW = $clog2(RES_CYC + 1);

  logic          r_lvl;
  logic [4:0]    r_rdat;
  logic [CW-1:0] r_cnt;
  logic          r_res_n;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_lvl_nxt;

  // A new auto-reset write reloads the counter even while a pulse is running.
  always_comb begin
    w_lvl_nxt = i_wr ? i_res_lvl : r_lvl;
    w_cnt_nxt = '0;
    if (i_wr && i_auto_res) begin
      w_cnt_nxt = CW'(RES_CYC);
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK_32) begin
    if (RESET) begin
      r_lvl   <= 1'b0;
      r_rdat  <= '0;
      r_cnt   <= '0;
      r_res_n <= 1'b0;
    end else begin
      if (i_wr) begin
        r_lvl  <= i_res_lvl;
        r_rdat <= i_rdat;
      end
      r_cnt   <= w_cnt_nxt;
      r_res_n <= w_lvl_nxt & (w_cnt_nxt == '0);
    end
  end

  assign o_res_n   = r_res_n;
  assign o_res_lvl = r_lvl;
  assign o_rdat    = r_rdat;
  assign o_rdatp   = ~^r_rdat;
  assign o_pulse   = (r_cnt != '0);

endmodule

// File: rtl/mko_bus_ctrl.sv
// Local-bus front end for up to five MKO channels: internal register space
// for per-channel configuration and a strobe FSM for device accesses.
module mko_bus_ctrl
  import mko_pkg::*;
#(
  parameter int         WB_DATA_WIDTH = 16,
  parameter int         WB_ADDR_WIDTH = 16,
  parameter int         N_CH          = 5,
  parameter logic [2:0] MKO_INT_REG   = 3'b101,
  parameter int         CLK_DIV       = 2,
  parameter int         STRB_CYC      = 4,
  parameter int         RES_CYC       = 16
) (
  input  logic                     CLK_32,
  input  logic                     RESET,
  input  logic [WB_DATA_WIDTH-1:0] Dat_slave_io_lbus,
  output logic [WB_DATA_WIDTH-1:0] Dat_slave_o_lbus,
  input  logic [WB_ADDR_WIDTH-1:0] Adr_slave_i_lbus_reg,
  input  logic                     We_slave_i_lbus_reg,
  input  logic                     ack_access_str,
  input  logic                     ack_access_reg_3,
  output logic                     ack_set_reg,
  output logic                     busy,
  output logic [N_CH-1:0]          MKO_CLK,
  output logic [N_CH-1:0]          MKO_RES_N,
  output logic [N_CH-1:0]          MKO_STRBD_N,
  output logic [N_CH-1:0]          MKO_SELECT_N,
  output logic [N_CH-1:0]          MKO_RDAT0,
  output logic [N_CH-1:0]          MKO_RDAT1,
  output logic [N_CH-1:0]          MKO_RDAT2,
  output logic [N_CH-1:0]          MKO_RDAT3,
  output logic [N_CH-1:0]          MKO_RDAT4,
  output logic [N_CH-1:0]          MKO_RDATP,
  output logic                     MKO_RDWR_N
);

  localparam int HALF = CLK_DIV / 2;

  logic [2:0]      w_req_ch;
  logic            w_req_valid;
  logic            w_int_space;
  logic            w_wr;
  logic            w_rd;
  logic [3:0]      w_ofs;
  logic            w_abort;
  logic [N_CH-1:0] w_wr_en;
  logic [N_CH-1:0] w_pulse;
  logic [N_CH-1:0] w_res_lvl;
  logic [N_CH-1:0] w_res_n;
  logic [N_CH-1:0] w_rdatp;
  logic [4:0]      w_rdat [N_CH];
  logic [7:0]      w_pulse8;
  logic [N_CH-1:0] w_req_sel_n;
  logic [N_CH-1:0] w_act_sel_n;
  logic [15:0]     w_rd_val;
  logic            w_unused_bits;

  mko_state_t      r_state;
  logic [2:0]      r_ch;
  logic            r_we;
  logic [15:0]     r_strb_cnt;
  logic [N_CH-1:0] r_select_n;
  logic [N_CH-1:0] r_strbd_n;
  logic            r_rdwr_n;
  logic            r_ack;
  logic            r_busy;
  logic [15:0]     r_dat_o;
  logic [15:0]     r_div_cnt;
  logic            r_mko_clk;

  assign w_req_ch      = Adr_slave_i_lbus_reg[15:13];
  assign w_req_valid   = (int'(w_req_ch) < N_CH) && (w_req_ch != MKO_INT_REG);
  assign w_int_space   = (Adr_slave_i_lbus_reg[15:13] == MKO_INT_REG);
  assign w_ofs         = Adr_slave_i_lbus_reg[3:0];
  assign w_wr          = ack_access_str && We_slave_i_lbus_reg && w_int_space;
  assign w_rd          = ack_access_str && !We_slave_i_lbus_reg && w_int_space;
  assign w_abort       = !ack_access_reg_3 && (r_state != ST_IDLE);
  assign w_unused_bits = ^{Adr_slave_i_lbus_reg[12:4], Dat_slave_io_lbus[13:5]};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_wr_en[g] = w_wr && (w_ofs == 4'(g));

    mko_chan_cfg #(.RES_CYC(RES_CYC)) u_cfg (
      .CLK_32     (CLK_32),
      .RESET      (RESET),
      .i_wr       (w_wr_en[g]),
      .i_res_lvl  (Dat_slave_io_lbus[RES_N_BIT]),
      .i_auto_res (Dat_slave_io_lbus[AUTO_RES_BIT]),
      .i_rdat     (Dat_slave_io_lbus[4:0]),
      .o_res_n    (w_res_n[g]),
      .o_res_lvl  (w_res_lvl[g]),
      .o_rdat     (w_rdat[g]),
      .o_rdatp    (w_rdatp[g]),
      .o_pulse    (w_pulse[g])
    );

    assign MKO_RDAT0[g] = w_rdat[g][0];
    assign MKO_RDAT1[g] = w_rdat[g][1];
    assign MKO_RDAT2[g] = w_rdat[g][2];
    assign MKO_RDAT3[g] = w_rdat[g][3];
    assign MKO_RDAT4[g] = w_rdat[g][4];
  end

  // Padded pulse vector lets a 3-bit channel index address it safely.
  always_comb begin
    w_pulse8 = '0;
    w_pulse8[N_CH-1:0] = w_pulse;
    w_req_sel_n = '1;
    w_act_sel_n = '1;
    for (int i = 0; i < N_CH; i++) begin
      if (w_req_ch == 3'(i)) w_req_sel_n[i] = 1'b0;
      if (r_ch == 3'(i))     w_act_sel_n[i] = 1'b0;
    end
  end

  always_comb begin
    w_rd_val = '0;
    if (w_ofs == STATUS_OFS) begin
      w_rd_val = {r_busy, 7'b0, w_pulse8};
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_ofs == 4'(i)) begin
          w_rd_val[RES_N_BIT] = w_res_lvl[i];
          w_rd_val[4:0]       = w_rdat[i];
        end
      end
    end
  end

  always_ff @(posedge CLK_32) begin
    if (RESET) begin
      r_dat_o   <= '0;
      r_div_cnt <= '0;
      r_mko_clk <= 1'b0;
    end else begin
      if (w_rd) r_dat_o <= w_rd_val;
      if (r_div_cnt == 16'(HALF - 1)) begin
        r_div_cnt <= '0;
        r_mko_clk <= ~r_mko_clk;
      end else begin
        r_div_cnt <= r_div_cnt + 16'd1;
      end
    end
  end

  // Invalid channels reach DONE without strobes; ack follows a cycle later.
  always_ff @(posedge CLK_32) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_ch       <= '0;
      r_we       <= 1'b0;
      r_strb_cnt <= '0;
      r_select_n <= '1;
      r_strbd_n  <= '1;
      r_rdwr_n   <= 1'b1;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
    end else if (w_abort) begin
      r_state    <= ST_IDLE;
      r_strb_cnt <= '0;
      r_select_n <= '1;
      r_strbd_n  <= '1;
      r_rdwr_n   <= 1'b1;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ack_access_reg_3) begin
            if (!w_req_valid) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b1;
            end else if (!w_pulse8[w_req_ch]) begin
              r_state    <= ST_SETUP;
              r_ch       <= w_req_ch;
              r_we       <= We_slave_i_lbus_reg;
              r_select_n <= w_req_sel_n;
              r_rdwr_n   <= ~We_slave_i_lbus_reg;
              r_busy     <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          r_state    <= ST_STRB;
          r_strbd_n  <= w_act_sel_n;
          r_rdwr_n   <= ~r_we;
          r_strb_cnt <= 16'(STRB_CYC - 1);
        end
        ST_STRB: begin
          if (r_strb_cnt == '0) begin
            r_state    <= ST_DONE;
            r_strbd_n  <= '1;
            r_select_n <= '1;
            r_rdwr_n   <= 1'b1;
            r_ack      <= 1'b1;
          end else begin
            r_strb_cnt <= r_strb_cnt - 16'd1;
          end
        end
        ST_DONE: begin
          r_strbd_n  <= '1;
          r_select_n <= '1;
          r_rdwr_n   <= 1'b1;
          r_ack      <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Dat_slave_o_lbus = r_dat_o;
  assign ack_set_reg      = r_ack;
  assign busy             = r_busy;
  assign MKO_CLK          = {N_CH{r_mko_clk}};
  assign MKO_RES_N        = w_res_n;
  assign MKO_RDATP        = w_rdatp;
  assign MKO_STRBD_N      = r_strbd_n;
  assign MKO_SELECT_N     = r_select_n;
  assign MKO_RDWR_N       = r_rdwr_n;

endmodule

// File: tb/tb_mko_bus_ctrl.sv
// Directed bench for mko_bus_ctrl: register space, auto-reset pulses,
// device strobe sequencing, invalid channels, aborts and reset priority.
module tb_mko_bus_ctrl;

  logic        CLK_32 = 1'b0;
  logic        RESET  = 1'b1;
  logic [15:0] Dat_i  = '0;
  logic [15:0] Dat_o;
  logic [15:0] Adr    = '0;
  logic        We     = 1'b0;
  logic        str    = 1'b0;
  logic        req    = 1'b0;
  logic        ack;
  logic        busy;
  logic [4:0]  MKO_CLK, MKO_RES_N, MKO_STRBD_N, MKO_SELECT_N;
  logic [4:0]  MKO_RDAT0, MKO_RDAT1, MKO_RDAT2, MKO_RDAT3, MKO_RDAT4, MKO_RDATP;
  logic        MKO_RDWR_N;

  int errors = 0;
  int checks = 0;

  mko_bus_ctrl dut (
    .CLK_32               (CLK_32),
    .RESET                (RESET),
    .Dat_slave_io_lbus    (Dat_i),
    .Dat_slave_o_lbus     (Dat_o),
    .Adr_slave_i_lbus_reg (Adr),
    .We_slave_i_lbus_reg  (We),
    .ack_access_str       (str),
    .ack_access_reg_3     (req),
    .ack_set_reg          (ack),
    .busy                 (busy),
    .MKO_CLK              (MKO_CLK),
    .MKO_RES_N            (MKO_RES_N),
    .MKO_STRBD_N          (MKO_STRBD_N),
    .MKO_SELECT_N         (MKO_SELECT_N),
    .MKO_RDAT0            (MKO_RDAT0),
    .MKO_RDAT1            (MKO_RDAT1),
    .MKO_RDAT2            (MKO_RDAT2),
    .MKO_RDAT3            (MKO_RDAT3),
    .MKO_RDAT4            (MKO_RDAT4),
    .MKO_RDATP            (MKO_RDATP),
    .MKO_RDWR_N           (MKO_RDWR_N)
  );

  always #5 CLK_32 = ~CLK_32;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [4:0] rdat_of(input int ch);
    return {MKO_RDAT4[ch], MKO_RDAT3[ch], MKO_RDAT2[ch], MKO_RDAT1[ch], MKO_RDAT0[ch]};
  endfunction

  task automatic tick();
    @(posedge CLK_32);
    #1;
  endtask

  task automatic reg_write(input logic [3:0] ofs, input logic [15:0] d);
    Adr = {3'b101, 9'b0, ofs};
    Dat_i = d;
    We = 1'b1;
    str = 1'b1;
    tick();
    str = 1'b0;
    We = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] ofs);
    Adr = {3'b101, 9'b0, ofs};
    We = 1'b0;
    str = 1'b1;
    tick();
    str = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    checks++; if (Dat_o !== 16'h0000) begin errors++; $display("[TB] FAIL rst_dat got=%h exp=0000", Dat_o); end
    checks++; if ({ack, busy, MKO_RDWR_N} !== 3'b001) begin errors++; $display("[TB] FAIL rst_ack_busy_rdwr got=%b exp=001", {ack, busy, MKO_RDWR_N}); end
    checks++; if ({MKO_SELECT_N, MKO_STRBD_N} !== 10'h3FF) begin errors++; $display("[TB] FAIL rst_sel_strb got=%b exp=1111111111", {MKO_SELECT_N, MKO_STRBD_N}); end
    checks++; if ({MKO_RDAT4, MKO_RDAT3, MKO_RDAT2, MKO_RDAT1, MKO_RDAT0} !== 25'd0) begin errors++; $display("[TB] FAIL rst_rdat got=%h exp=0", {MKO_RDAT4, MKO_RDAT3, MKO_RDAT2, MKO_RDAT1, MKO_RDAT0}); end
    checks++; if (MKO_RDATP !== 5'b11111) begin errors++; $display("[TB] FAIL rst_rdatp got=%b exp=11111", MKO_RDATP); end
    checks++; if ({MKO_RES_N, MKO_CLK} !== 10'h000) begin errors++; $display("[TB] FAIL rst_resn_clk got=%b exp=0000000000", {MKO_RES_N, MKO_CLK}); end
    RESET = 1'b0;
  endtask

  task automatic test_clk();
    tick();
    checks++; if (MKO_CLK !== 5'b11111) begin errors++; $display("[TB] FAIL clk_hi got=%b exp=11111", MKO_CLK); end
    tick();
    checks++; if (MKO_CLK !== 5'b00000) begin errors++; $display("[TB] FAIL clk_lo got=%b exp=00000", MKO_CLK); end
  endtask

  task automatic test_cfg_write();
    reg_write(4'd2, 16'h8015);
    checks++; if (rdat_of(2) !== 5'b10101) begin errors++; $display("[TB] FAIL cfg_rdat2 got=%b exp=10101", rdat_of(2)); end
    checks++; if (MKO_RDATP !== 5'b11011) begin errors++; $display("[TB] FAIL cfg_rdatp got=%b exp=11011", MKO_RDATP); end
    checks++; if (MKO_RES_N !== 5'b00100) begin errors++; $display("[TB] FAIL cfg_resn got=%b exp=00100", MKO_RES_N); end
    reg_read(4'd2);
    checks++; if (Dat_o !== 16'h8015) begin errors++; $display("[TB] FAIL cfg_read2 got=%h exp=8015", Dat_o); end
    tick();
    checks++; if (Dat_o !== 16'h8015) begin errors++; $display("[TB] FAIL cfg_read_hold got=%h exp=8015", Dat_o); end
    reg_write(4'hF, 16'hC01F);
    reg_write(4'h7, 16'hC01F);
    checks++; if ({MKO_RES_N, MKO_RDATP} !== 10'b00100_11011) begin errors++; $display("[TB] FAIL cfg_ignored_wr got=%b exp=0010011011", {MKO_RES_N, MKO_RDATP}); end
    reg_read(4'hF);
    checks++; if (Dat_o !== 16'h0000) begin errors++; $display("[TB] FAIL cfg_status_idle got=%h exp=0000", Dat_o); end
    reg_read(4'd2);
    reg_read(4'd9);
    checks++; if (Dat_o !== 16'h0000) begin errors++; $display("[TB] FAIL cfg_read_unmapped got=%h exp=0000", Dat_o); end
  endtask

  task automatic test_auto_reset();
    int n;
    reg_write(4'd1, 16'h8000);
    checks++; if (MKO_RES_N !== 5'b00110) begin errors++; $display("[TB] FAIL ar_static got=%b exp=00110", MKO_RES_N); end
    reg_write(4'd1, 16'h4000);
    checks++; if (MKO_RES_N !== 5'b00100) begin errors++; $display("[TB] FAIL ar_pulse_low got=%b exp=00100", MKO_RES_N); end
    reg_read(4'hF);
    checks++; if (Dat_o !== 16'h0002) begin errors++; $display("[TB] FAIL ar_status_pulse got=%h exp=0002", Dat_o); end
    repeat (20) tick();
    reg_read(4'hF);
    checks++; if (Dat_o !== 16'h0000) begin errors++; $display("[TB] FAIL ar_status_after got=%h exp=0000", Dat_o); end
    reg_write(4'd1, 16'hC003);
    n = 0;
    while (MKO_RES_N[1] === 1'b0 && n < 40) begin n++; tick(); end
    checks++; if (n != 16) begin errors++; $display("[TB] FAIL ar_width got=%0d exp=16", n); end
    checks++; if (MKO_RES_N !== 5'b00110) begin errors++; $display("[TB] FAIL ar_return got=%b exp=00110", MKO_RES_N); end
    reg_write(4'd1, 16'hC003);
    repeat (8) tick();
    reg_write(4'd1, 16'hC003);
    n = 0;
    while (MKO_RES_N[1] === 1'b0 && n < 40) begin n++; tick(); end
    checks++; if (n != 16) begin errors++; $display("[TB] FAIL ar_restart_width got=%0d exp=16", n); end
  endtask

  task automatic test_dev_access();
    Adr = 16'h6000; We = 1'b1; req = 1'b1;
    tick();
    checks++; if ({MKO_SELECT_N, MKO_STRBD_N} !== 10'b10111_11111) begin errors++; $display("[TB] FAIL dev_setup got=%b exp=1011111111", {MKO_SELECT_N, MKO_STRBD_N}); end
    checks++; if ({MKO_RDWR_N, busy, ack} !== 3'b010) begin errors++; $display("[TB] FAIL dev_setup_ctl got=%b exp=010", {MKO_RDWR_N, busy, ack}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({MKO_SELECT_N, MKO_STRBD_N, MKO_RDWR_N} !== 11'b10111_10111_0) begin errors++; $display("[TB] FAIL dev_strb%0d got=%b exp=10111101110", i, {MKO_SELECT_N, MKO_STRBD_N, MKO_RDWR_N}); end
    end
    tick();
    checks++; if ({MKO_SELECT_N, MKO_STRBD_N, MKO_RDWR_N, ack} !== 12'hFFF) begin errors++; $display("[TB] FAIL dev_done got=%b exp=111111111111", {MKO_SELECT_N, MKO_STRBD_N, MKO_RDWR_N, ack}); end
    repeat (3) tick();
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL dev_ack_hold got=%b exp=1", ack); end
    req = 1'b0; We = 1'b0;
    tick();
    checks++; if ({ack, busy} !== 2'b00) begin errors++; $display("[TB] FAIL dev_release got=%b exp=00", {ack, busy}); end
  endtask

  task automatic test_invalid_ch();
    Adr = 16'hC000; req = 1'b1;
    tick();
    checks++; if ({ack, busy, MKO_SELECT_N, MKO_STRBD_N} !== 12'b01_11111_11111) begin errors++; $display("[TB] FAIL inv_first got=%b exp=011111111111", {ack, busy, MKO_SELECT_N, MKO_STRBD_N}); end
    tick();
    checks++; if ({ack, MKO_STRBD_N} !== 6'b1_11111) begin errors++; $display("[TB] FAIL inv_ack got=%b exp=111111", {ack, MKO_STRBD_N}); end
    req = 1'b0;
    tick();
    checks++; if ({ack, busy} !== 2'b00) begin errors++; $display("[TB] FAIL inv_release got=%b exp=00", {ack, busy}); end
    Adr = 16'hA000; req = 1'b1;
    tick();
    tick();
    checks++; if ({ack, MKO_SELECT_N} !== 6'b1_11111) begin errors++; $display("[TB] FAIL inv_intreg got=%b exp=111111", {ack, MKO_SELECT_N}); end
    req = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    Adr = 16'h6000; We = 1'b1; req = 1'b1;
    repeat (3) tick();
    checks++; if (MKO_STRBD_N !== 5'b10111) begin errors++; $display("[TB] FAIL abort_pre got=%b exp=10111", MKO_STRBD_N); end
    req = 1'b0;
    tick();
    checks++; if ({MKO_SELECT_N, MKO_STRBD_N, MKO_RDWR_N, ack, busy} !== 13'b11111_11111_1_0_0) begin errors++; $display("[TB] FAIL abort_next got=%b exp=1111111111100", {MKO_SELECT_N, MKO_STRBD_N, MKO_RDWR_N, ack, busy}); end
    We = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_stays_idle got=%b exp=0", busy); end
  endtask

  task automatic test_parallel_write();
    int n;
    Adr = 16'h0000; We = 1'b0; req = 1'b1;
    tick();
    checks++; if ({MKO_SELECT_N, MKO_RDWR_N} !== 6'b11110_1) begin errors++; $display("[TB] FAIL par_setup got=%b exp=111101", {MKO_SELECT_N, MKO_RDWR_N}); end
    tick();
    reg_write(4'd0, 16'h8007);
    checks++; if ({rdat_of(0), MKO_STRBD_N, busy} !== 11'b00111_11110_1) begin errors++; $display("[TB] FAIL par_rdat got=%b exp=00111111101", {rdat_of(0), MKO_STRBD_N, busy}); end
    n = 0;
    while (ack !== 1'b1 && n < 20) begin n++; tick(); end
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL par_ack_timeout got=%b exp=1", ack); end
    req = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL par_release got=%b exp=0", busy); end
  endtask

  task automatic test_stall();
    int n;
    reg_write(4'd2, 16'h4000);
    Adr = 16'h4000; We = 1'b1; req = 1'b1;
    repeat (5) tick();
    checks++; if ({busy, MKO_SELECT_N, MKO_STRBD_N} !== 11'b0_11111_11111) begin errors++; $display("[TB] FAIL stall_hold got=%b exp=01111111111", {busy, MKO_SELECT_N, MKO_STRBD_N}); end
    n = 0;
    while (busy !== 1'b1 && n < 40) begin n++; tick(); end
    checks++; if (n != 12) begin errors++; $display("[TB] FAIL stall_start_cycle got=%0d exp=12", n); end
    checks++; if (MKO_SELECT_N !== 5'b11011) begin errors++; $display("[TB] FAIL stall_select got=%b exp=11011", MKO_SELECT_N); end
    n = 0;
    while (ack !== 1'b1 && n < 20) begin n++; tick(); end
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL stall_ack_timeout got=%b exp=1", ack); end
    req = 1'b0; We = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    reg_write(4'd4, 16'hC01F);
    reg_read(4'd0);
    checks++; if (Dat_o !== 16'h8007) begin errors++; $display("[TB] FAIL rm_read0 got=%h exp=8007", Dat_o); end
    Adr = 16'h6000; We = 1'b1; req = 1'b1;
    repeat (3) tick();
    checks++; if (MKO_STRBD_N !== 5'b10111) begin errors++; $display("[TB] FAIL rm_in_strb got=%b exp=10111", MKO_STRBD_N); end
    RESET = 1'b1;
    tick();
    checks++; if ({Dat_o, ack, busy, MKO_RDWR_N} !== 19'b0000000000000000_0_0_1) begin errors++; $display("[TB] FAIL rm_dat_ctl got=%b exp=0000000000000000001", {Dat_o, ack, busy, MKO_RDWR_N}); end
    checks++; if ({MKO_SELECT_N, MKO_STRBD_N, MKO_RDATP} !== 15'h7FFF) begin errors++; $display("[TB] FAIL rm_strobes got=%b exp=111111111111111", {MKO_SELECT_N, MKO_STRBD_N, MKO_RDATP}); end
    checks++; if ({MKO_RDAT4, MKO_RDAT3, MKO_RDAT2, MKO_RDAT1, MKO_RDAT0, MKO_RES_N, MKO_CLK} !== 35'd0) begin errors++; $display("[TB] FAIL rm_pins got=%h exp=0", {MKO_RDAT4, MKO_RDAT3, MKO_RDAT2, MKO_RDAT1, MKO_RDAT0, MKO_RES_N, MKO_CLK}); end
    RESET = 1'b0; req = 1'b0; We = 1'b0;
    tick();
    reg_read(4'hF);
    checks++; if (Dat_o !== 16'h0000) begin errors++; $display("[TB] FAIL rm_status_clear got=%h exp=0000", Dat_o); end
  endtask

  initial begin
    $display("[TB] starting mko_bus_ctrl bench");
    test_reset();
    test_clk();
    test_cfg_write();
    test_auto_reset();
    test_dev_access();
    test_invalid_ch();
    test_abort();
    test_parallel_write();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
